execute_muldiv: RTL and testbench

Parametrised multi-cycle multiply/divide unit with HI/LO state. It sits beside the single-cycle ALU in the execute stage and handles MULT/MULTU/DIV/DIVU, MFHI/MFLO and MTHI/MTLO. It uses an iterative datapath with a valid/ready handshake, a busy stall towards the pipeline, and a flush input for squashed instructions. Divide semantics follow MIPS: quotient goes to LO, remainder to HI.

---
 rtl/execute_muldiv.sv | 164 ++++++++++++++++
 tb/tb_execute_muldiv.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO, valid/ready intake and flush.
// state | meaning
// IDLE  | accepting ops; MFxx/MTxx complete here
// ITER  | one multiplier / quotient bit per cycle, cnt_q counts down to 1
// FIX   | two's-complement sign fixup, HI/LO write
module execute_muldiv #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  output logic [0:WIDTH-1] out_data,
  output logic [0:WIDTH-1] hi,
  output logic [0:WIDTH-1] lo
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               div_q, neg_lo_q, neg_hi_q;
  logic [2*WIDTH-1:0] acc_q, mcand_q;
  logic [WIDTH-1:0]   shreg_q, rem_q, dsor_q;
  logic [WIDTH-1:0]   hi_q, lo_q, out_data_q;
  logic               out_valid_q, done_q;

  logic [WIDTH-1:0] a_v, b_v, a_mag, b_mag;
  logic             accept, is_muldiv, op_signed, op_div, a_neg, b_neg, div_zero;

  assign a_v       = a;
  assign b_v       = b;
  assign in_ready  = (state_q == S_IDLE) && !flush;
  assign busy      = (state_q != S_IDLE);
  assign accept    = in_valid && in_ready;
  assign is_muldiv = !op[2];
  assign op_signed = !op[0];
  assign op_div    = op[1];
  assign a_neg     = op_signed && a_v[WIDTH-1];
  assign b_neg     = op_signed && b_v[WIDTH-1];
  assign a_mag     = a_neg ? -a_v : a_v;
  assign b_mag     = b_neg ? -b_v : b_v;
  assign div_zero  = (b_v == '0);

  // Shift-add step: multiplier LSB selects whether the shifted multiplicand is added.
  logic [2*WIDTH-1:0] acc_nx;
  assign acc_nx = shreg_q[0] ? acc_q + mcand_q : acc_q;

  // Restoring step: the dividend shifts out of shreg_q while quotient bits shift in.
  logic [WIDTH:0] partial, diff;
  logic           fits;
  assign partial = {rem_q, shreg_q[WIDTH-1]};
  assign fits    = partial >= {1'b0, dsor_q};
  assign diff    = partial - {1'b0, dsor_q};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_lo_q ? -acc_q : acc_q;
  assign quo_fix  = neg_lo_q ? -shreg_q : shreg_q;
  assign rem_fix  = neg_hi_q ? -rem_q : rem_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && is_muldiv) state_d = S_ITER;
      S_ITER: begin
        if (flush)                          state_d = S_IDLE;
        else if (cnt_q == CNT_W'(1))        state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      div_q       <= 1'b0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      shreg_q     <= '0;
      rem_q       <= '0;
      dsor_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (is_muldiv) begin
              cnt_q    <= CNT_W'(WIDTH);
              div_q    <= op_div;
              acc_q    <= '0;
              rem_q    <= '0;
              mcand_q  <= {{WIDTH{1'b0}}, a_mag};
              dsor_q   <= b_mag;
              // Divide by zero runs the raw dividend through so HI ends up equal to a.
              shreg_q  <= op_div ? (div_zero ? a_v : a_mag) : b_mag;
              neg_lo_q <= (a_neg ^ b_neg) && !(op_div && div_zero);
              neg_hi_q <= a_neg && !div_zero;
            end else if (op[1]) begin
              if (op[0]) lo_q <= a_v;
              else       hi_q <= a_v;
            end else begin
              out_data_q  <= op[0] ? lo_q : hi_q;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_ITER: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (div_q) begin
            rem_q   <= fits ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
            shreg_q <= {shreg_q[WIDTH-2:0], fits};
          end else begin
            acc_q   <= acc_nx;
            mcand_q <= mcand_q << 1;
            shreg_q <= shreg_q >> 1;
          end
        end
        S_FIX: begin
          if (!flush) begin
            if (div_q) begin
              lo_q <= quo_fix;
              hi_q <= rem_fix;
            end else begin
              lo_q <= prod_fix[WIDTH-1:0];
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            end
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv: table vectors plus random ops scored against a reference
// model, and directed flush / reset / held-MFxx sequences; a second instance at WIDTH=8.
module tb_execute_muldiv;
  localparam int W = 32;
  localparam int W8 = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0, flush = 1'b0;
  logic [2:0]    op = '0;
  logic [0:W-1]  a = '0, b = '0;
  logic          in_ready, busy, done, out_valid;
  logic [0:W-1]  out_data, hi, lo;

  logic          v8 = 1'b0, flush8 = 1'b0;
  logic [2:0]    op8 = '0;
  logic [0:W8-1] a8 = '0, b8 = '0;
  logic          in_ready8, busy8, done8, out_valid8;
  logic [0:W8-1] out_data8, hi8, lo8;

  always #5 clock = ~clock;

  execute_muldiv #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .flush(flush), .busy(busy), .done(done), .out_valid(out_valid),
    .out_data(out_data), .hi(hi), .lo(lo));

  execute_muldiv #(.WIDTH(W8)) dut8 (
    .clock(clock), .reset_n(reset_n), .in_valid(v8), .in_ready(in_ready8), .op(op8),
    .a(a8), .b(b8), .flush(flush8), .busy(busy8), .done(done8), .out_valid(out_valid8),
    .out_data(out_data8), .hi(hi8), .lo(lo8));

  typedef struct { logic [2:0] op; logic [W-1:0] a, b, hi, lo; } vec_t;
  typedef struct { logic [2:0] op; logic [W8-1:0] a, b, hi, lo; } vec8_t;
  typedef struct { logic [W-1:0] hi, lo; } res_t;

  res_t         sb[$];
  logic [W-1:0] oq[$];
  logic [W-1:0] hi_m = '0, lo_m = '0;
  int n_checks = 0, n_fail = 0, cyc = 0, done_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string got, input string req);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %s, required %s", name, got, req);
  endtask

  always @(negedge clock) begin
    res_t e;
    logic [W-1:0] d;
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) fail("done_pulse", "done with no pending op", "no done");
      else begin
        e = sb.pop_front();
        chk("sb_hi", hi, e.hi);
        chk("sb_lo", lo, e.lo);
      end
    end
    if (out_valid) begin
      if (oq.size() == 0) fail("out_valid_pulse", "out_valid with no pending MFxx", "no out_valid");
      else begin
        d = oq.pop_front();
        chk("mf_out_data", out_data, d);
      end
    end
  end

  function automatic res_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] sx, sy, sq, sr;
    logic [2*W-1:0] p;
    res_t r;
    sx = $signed({{W{x[W-1]}}, x});
    sy = $signed({{W{y[W-1]}}, y});
    r.hi = '0;
    r.lo = '0;
    case (o)
      3'd0: begin p = sx * sy; r.hi = p[2*W-1:W]; r.lo = p[W-1:0]; end
      3'd1: begin p = {{W{1'b0}}, x} * {{W{1'b0}}, y}; r.hi = p[2*W-1:W]; r.lo = p[W-1:0]; end
      default: begin
        if (y == '0) begin r.lo = '1; r.hi = x; end
        else if (o == 3'd2) begin sq = sx / sy; sr = sx % sy; r.lo = sq[W-1:0]; r.hi = sr[W-1:0]; end
        else begin r.lo = x / y; r.hi = x % y; end
      end
    endcase
    return r;
  endfunction

  // Offers an op, waits for in_ready, returns the cycle index of the accept edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input bit track,
                       output int acc);
    int n;
    @(negedge clock);
    op = o; a = av; b = bv; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clock); n++; end
    if (!in_ready) begin
      fail("accept_timeout", "in_ready low for 200 cycles", "in_ready high");
      in_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clock);
    #1;
    acc = cyc;
    in_valid = 1'b0;
    if (!o[2]) begin
      if (track) begin sb.push_back('{eh, el}); hi_m = eh; lo_m = el; end
    end else if (o[1]) begin
      if (o[0]) lo_m = av; else hi_m = av;
    end else oq.push_back(o[0] ? lo_m : hi_m);
  endtask

  task automatic wait_done(input int acc);
    int n, nb;
    n = 0; nb = 0;
    do begin
      @(negedge clock);
      n++;
      if (busy) nb++;
    end while (!done && n < 200);
    if (!done) fail("done_timeout", "no done in 200 cycles", "done pulse");
    else begin
      chk("done_latency", cyc - acc, W + 1);
      chk("busy_cycles", nb, W + 1);
    end
  endtask

  task automatic run8(input vec8_t v);
    int n, acc;
    @(negedge clock);
    op8 = v.op; a8 = v.a; b8 = v.b; v8 = 1'b1;
    n = 0;
    while (!in_ready8 && n < 50) begin @(negedge clock); n++; end
    @(posedge clock);
    #1;
    acc = cyc;
    v8 = 1'b0;
    n = 0;
    do begin @(negedge clock); n++; end while (!done8 && n < 50);
    if (!done8) fail("w8_done_timeout", "no done in 50 cycles", "done pulse");
    else begin
      chk("w8_latency", cyc - acc, W8 + 1);
      chk("w8_hi", hi8, v.hi);
      chk("w8_lo", lo8, v.lo);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t  tbl[13];
    vec8_t t8[6];
    res_t  r;
    int    acc, acc2, d0;
    logic [W-1:0] x, y;
    logic [2:0]   o;

    tbl[0]  = '{3'd0, 32'hFFFFFFFD, 32'h7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    tbl[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tbl[2]  = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14};
    tbl[3]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000};
    tbl[5]  = '{3'd2, 32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF};
    tbl[6]  = '{3'd2, 32'h87654321, 32'h0,        32'h87654321, 32'hFFFFFFFF};
    tbl[7]  = '{3'd0, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    tbl[8]  = '{3'd2, 32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD};
    tbl[9]  = '{3'd6, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
    tbl[10] = '{3'd7, 32'h0BADF00D, 32'h0,        32'h0,        32'h0BADF00D};
    tbl[11] = '{3'd4, 32'h0,        32'h0,        32'h0,        32'h0};
    tbl[12] = '{3'd5, 32'h0,        32'h0,        32'h0,        32'h0};

    t8[0] = '{3'd0, 8'hFD, 8'h07, 8'hFF, 8'hEB};
    t8[1] = '{3'd1, 8'hFF, 8'hFF, 8'hFE, 8'h01};
    t8[2] = '{3'd3, 8'd100, 8'd7, 8'd2, 8'd14};
    t8[3] = '{3'd2, 8'hF9, 8'd2, 8'hFF, 8'hFD};
    t8[4] = '{3'd2, 8'h80, 8'hFF, 8'h00, 8'h80};
    t8[5] = '{3'd2, 8'h12, 8'h00, 8'h12, 8'hFF};

    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, 1'b1, acc);
      if (!tbl[i].op[2]) wait_done(acc);
      else begin
        @(negedge clock);
        if (tbl[i].op[1]) begin
          if (tbl[i].op[0]) chk("mtlo", lo, tbl[i].lo);
          else              chk("mthi", hi, tbl[i].hi);
          chk("mt_no_out_valid", out_valid, 0);
        end else begin
          chk("mf_out_valid", out_valid, 1);
          @(negedge clock);
          chk("mf_out_valid_pulse", out_valid, 0);
          chk("mf_out_data_hold", out_data, tbl[i].op[0] ? 32'h0BADF00D : 32'hDEADBEEF);
        end
      end
    end

    for (int i = 0; i < 8; i++) begin
      o = 3'($urandom_range(0, 3));
      x = $urandom;
      y = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i == 5) y = 32'hFFFFFFF5;
      r = model(o, x, y);
      issue(o, x, y, r.hi, r.lo, 1'b1, acc);
      wait_done(acc);
    end

    // Flush part-way through a divide leaves HI/LO untouched and produces no done.
    issue(3'd6, 32'hAAAA5555, 32'h0, 32'h0, 32'h0, 1'b1, acc);
    @(negedge clock);
    chk("mthi_flush_setup", hi, 32'hAAAA5555);
    issue(3'd3, 32'd1000, 32'd3, 32'h0, 32'h0, 1'b0, acc);
    d0 = done_cnt;
    repeat (10) @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    @(negedge clock);
    chk("flush_busy", busy, 0);
    chk("flush_hi", hi, 32'hAAAA5555);
    repeat (W + 4) @(negedge clock);
    chk("flush_no_done", done_cnt, d0);

    // Flush while idle holds off acceptance.
    @(negedge clock);
    flush = 1'b1; op = 3'd7; a = 32'h13572468; in_valid = 1'b1;
    #1;
    chk("flush_idle_in_ready", in_ready, 0);
    @(posedge clock);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    chk("flush_idle_lo", lo, lo_m);
    issue(3'd4, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, acc);
    @(negedge clock);
    chk("mfhi_after_flush_valid", out_valid, 1);

    // MFLO offered during a multiply is taken in the first idle cycle.
    issue(3'd0, 32'h00012345, 32'h00001000, 32'h0, 32'h12345000, 1'b1, acc);
    issue(3'd5, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, acc2);
    chk("mflo_accept_edge", acc2 - acc, W + 2);
    @(negedge clock);
    chk("mflo_held_valid", out_valid, 1);

    // Reset in the middle of a multiply discards it.
    issue(3'd6, 32'h5A5A5A5A, 32'h0, 32'h0, 32'h0, 1'b1, acc);
    issue(3'd0, 32'h3, 32'h3, 32'h0, 32'h0, 1'b0, acc);
    d0 = done_cnt;
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_in_ready", in_ready, 1);
    hi_m = '0; lo_m = '0;
    repeat (2) @(negedge clock);
    chk("midrst_out_valid", out_valid, 0);
    reset_n = 1'b1;
    repeat (W + 4) @(negedge clock);
    chk("midrst_no_done", done_cnt, d0);

    for (int i = 0; i < 6; i++) run8(t8[i]);

    repeat (3) @(negedge clock);
    chk("sb_drained", sb.size() + oq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
